// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP controller state encoding and instruction opcodes.
// Used by the TAP controller, the instruction register and the data register blocks.
package jtag_pkg;

    // 4-bit TAP state encoding, identical to the one the TAP controller drives.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // Opcodes are held at 8 bits and truncated to the IR width at each use.
    localparam logic [7:0] OP_SAMPLE   = 8'h01;
    localparam logic [7:0] OP_EXTEST   = 8'h02;
    localparam logic [7:0] OP_INTEST   = 8'h03;
    localparam logic [7:0] OP_RUNBIST  = 8'h04;
    localparam logic [7:0] OP_CLAMP    = 8'h05;
    localparam logic [7:0] OP_IDCODE   = 8'h07;
    localparam logic [7:0] OP_USERCODE = 8'h08;
    localparam logic [7:0] OP_HIGHZ    = 8'h09;

    function automatic logic opFits(input logic [7:0] op, input int width);
        return (op >> width) == 8'd0;
    endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational opcode validation (for the shift register value about to be committed)
// and one-hot decode of the active instruction.
module ir_decode
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = 4
) (
    input  logic [IR_WIDTH-1:0] candidate_i,
    output logic [IR_WIDTH-1:0] validated_o,
    input  logic [IR_WIDTH-1:0] active_i,
    output logic                selBypass_o,
    output logic                selIdcode_o,
    output logic                selUsercode_o,
    output logic                selSample_o,
    output logic                selExtest_o,
    output logic                selIntest_o,
    output logic                selRunbist_o,
    output logic                selClamp_o,
    output logic                selHighz_o,
    output logic                testMode_o
);

    localparam logic [IR_WIDTH-1:0] ALL_ONES = {IR_WIDTH{1'b1}};

    // All ones always means BYPASS, even where a narrow IR makes it alias another opcode.
    function automatic logic isOp(input logic [IR_WIDTH-1:0] v, input logic [7:0] op);
        return opFits(op, IR_WIDTH) && (v == IR_WIDTH'(op)) && (v != ALL_ONES);
    endfunction

    logic candKnown;

    always_comb begin
        candKnown = (candidate_i == ALL_ONES)
                 || isOp(candidate_i, OP_SAMPLE)
                 || isOp(candidate_i, OP_EXTEST)
                 || isOp(candidate_i, OP_INTEST)
                 || isOp(candidate_i, OP_RUNBIST)
                 || isOp(candidate_i, OP_CLAMP)
                 || isOp(candidate_i, OP_IDCODE)
                 || isOp(candidate_i, OP_USERCODE)
                 || isOp(candidate_i, OP_HIGHZ);
        validated_o = candKnown ? candidate_i : ALL_ONES;
    end

    assign selIdcode_o   = isOp(active_i, OP_IDCODE);
    assign selUsercode_o = isOp(active_i, OP_USERCODE);
    assign selSample_o   = isOp(active_i, OP_SAMPLE);
    assign selExtest_o   = isOp(active_i, OP_EXTEST);
    assign selIntest_o   = isOp(active_i, OP_INTEST);
    assign selRunbist_o  = isOp(active_i, OP_RUNBIST);
    assign selClamp_o    = isOp(active_i, OP_CLAMP);
    assign selHighz_o    = isOp(active_i, OP_HIGHZ);

    // Anything not recognised decodes as BYPASS so exactly one select is always high.
    assign selBypass_o = !(selIdcode_o || selUsercode_o || selSample_o || selExtest_o
                        || selIntest_o || selRunbist_o || selClamp_o || selHighz_o);

    assign testMode_o = selExtest_o | selIntest_o | selRunbist_o | selClamp_o | selHighz_o;

endmodule

// File: rtl/ir_shift.sv
// JTAG instruction register: capture/shift register plus the separately updated active
// instruction, its one-hot decode and an update strobe.
module ir_shift
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(4'h7),
    parameter bit                  USE_IDCODE = 1'b1
) (
    input  logic                TCK,
    input  logic                rst,
    input  logic                TDI,
    input  logic [3:0]          state,
    // A 2-bit IR has no status bits; the port stays 1 bit wide and is ignored then.
    input  logic [((IR_WIDTH > 2) ? IR_WIDTH - 3 : 0):0] capture_status,
    output logic                TDO_IR,
    output logic [IR_WIDTH-1:0] JTAG_IR,
    output logic                sel_bypass,
    output logic                sel_idcode,
    output logic                sel_usercode,
    output logic                sel_sample,
    output logic                sel_extest,
    output logic                sel_intest,
    output logic                sel_runbist,
    output logic                sel_clamp,
    output logic                sel_highz,
    output logic                test_mode,
    output logic                ir_updated
);

    localparam logic [IR_WIDTH-1:0] RESET_OP = USE_IDCODE ? IDCODE_OP : {IR_WIDTH{1'b1}};

    logic [IR_WIDTH-1:0] shreg_q, shreg_d;
    logic [IR_WIDTH-1:0] jtagIr_q, jtagIr_d;
    logic                irUpdated_q, irUpdated_d;
    logic [IR_WIDTH-1:0] captureVal;
    logic [IR_WIDTH-1:0] validated;

    // The truncating cast drops the unused status bit when IR_WIDTH is 2.
    assign captureVal = IR_WIDTH'({capture_status, 2'b01});

    ir_decode #(
        .IR_WIDTH (IR_WIDTH)
    ) u_decode (
        .candidate_i   (shreg_q),
        .validated_o   (validated),
        .active_i      (jtagIr_q),
        .selBypass_o   (sel_bypass),
        .selIdcode_o   (sel_idcode),
        .selUsercode_o (sel_usercode),
        .selSample_o   (sel_sample),
        .selExtest_o   (sel_extest),
        .selIntest_o   (sel_intest),
        .selRunbist_o  (sel_runbist),
        .selClamp_o    (sel_clamp),
        .selHighz_o    (sel_highz),
        .testMode_o    (test_mode)
    );

    always_comb begin
        shreg_d     = shreg_q;
        jtagIr_d    = jtagIr_q;
        irUpdated_d = 1'b0;
        case (state)
            TEST_LOGIC_RESET: begin
                shreg_d  = RESET_OP;
                jtagIr_d = RESET_OP;
            end
            CAPTURE_IR: shreg_d = captureVal;
            SHIFT_IR:   shreg_d = {TDI, shreg_q[IR_WIDTH-1:1]};
            UPDATE_IR: begin
                jtagIr_d    = validated;
                irUpdated_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (rst) begin
            shreg_q     <= RESET_OP;
            jtagIr_q    <= RESET_OP;
            irUpdated_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            jtagIr_q    <= jtagIr_d;
            irUpdated_q <= irUpdated_d;
        end
    end

    assign TDO_IR     = shreg_q[0];
    assign JTAG_IR    = jtagIr_q;
    assign ir_updated = irUpdated_q;

endmodule

// File: tb/tb_ir_shift.sv
// Directed bench for ir_shift: a 4-bit and a 6-bit instance driven from one TAP state stream,
// checked with immediate assertions against hand-computed values.
module tb_ir_shift;
    import jtag_pkg::*;

    logic       TCK;
    logic       rst;
    logic       TDI;
    logic [3:0] state;
    logic [1:0] cap4;
    logic [3:0] cap6;

    logic       tdo4, bypass4, idcode4, usercode4, sample4, extest4, intest4;
    logic       runbist4, clamp4, highz4, testMode4, irUpd4;
    logic [3:0] jtag4;
    logic [8:0] sel4;

    logic       tdo6, bypass6, idcode6, usercode6, sample6, extest6, intest6;
    logic       runbist6, clamp6, highz6, testMode6, irUpd6;
    logic [5:0] jtag6;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    localparam logic [8:0] SEL_BYPASS   = 9'b100000000;
    localparam logic [8:0] SEL_IDCODE   = 9'b010000000;
    localparam logic [8:0] SEL_USERCODE = 9'b001000000;
    localparam logic [8:0] SEL_EXTEST   = 9'b000010000;
    localparam logic [8:0] SEL_HIGHZ    = 9'b000000001;

    assign sel4 = {bypass4, idcode4, usercode4, sample4, extest4, intest4, runbist4, clamp4, highz4};

    ir_shift #(.IR_WIDTH(4)) dut4 (
        .TCK(TCK), .rst(rst), .TDI(TDI), .state(state), .capture_status(cap4),
        .TDO_IR(tdo4), .JTAG_IR(jtag4),
        .sel_bypass(bypass4), .sel_idcode(idcode4), .sel_usercode(usercode4),
        .sel_sample(sample4), .sel_extest(extest4), .sel_intest(intest4),
        .sel_runbist(runbist4), .sel_clamp(clamp4), .sel_highz(highz4),
        .test_mode(testMode4), .ir_updated(irUpd4)
    );

    ir_shift #(.IR_WIDTH(6)) dut6 (
        .TCK(TCK), .rst(rst), .TDI(TDI), .state(state), .capture_status(cap6),
        .TDO_IR(tdo6), .JTAG_IR(jtag6),
        .sel_bypass(bypass6), .sel_idcode(idcode6), .sel_usercode(usercode6),
        .sel_sample(sample6), .sel_extest(extest6), .sel_intest(intest6),
        .sel_runbist(runbist6), .sel_clamp(clamp6), .sel_highz(highz6),
        .test_mode(testMode6), .ir_updated(irUpd6)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // One TCK cycle in the given TAP state; outputs are then sampled on the falling edge.
    task automatic applyStimulus(input tap_state_e st, input logic tdi);
        state = st;
        TDI   = tdi;
        @(posedge TCK);
        @(negedge TCK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst   = 1'b1;
        TDI   = 1'b0;
        state = RUN_TEST_IDLE;
        cap4  = 2'b00;
        cap6  = 4'hA;
        @(negedge TCK);
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        rst = 1'b0;

        checkOutput("rst jtag4",     32'(jtag4), 32'h7);
        checkOutput("rst sel4",      32'(sel4), 32'(SEL_IDCODE));
        checkOutput("rst testMode4", 32'(testMode4), 32'd0);
        checkOutput("rst tdo4",      32'(tdo4), 32'd1);
        checkOutput("rst irUpd4",    32'(irUpd4), 32'd0);
        checkOutput("rst jtag6",     32'(jtag6), 32'h07);
        checkOutput("rst idcode6",   32'(idcode6), 32'd1);
        checkOutput("rst tdo6",      32'(tdo6), 32'd1);

        // Capture 2'b10 -> 4'b1001, shift in 0,1,0,0 -> EXTEST.
        cap4 = 2'b10;
        applyStimulus(CAPTURE_IR, 1'b0);
        checkOutput("ext tdo0",      32'(tdo4), 32'd1);
        checkOutput("ext cap jtag",  32'(jtag4), 32'h7);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("ext tdo1",      32'(tdo4), 32'd0);
        applyStimulus(SHIFT_IR, 1'b1);
        checkOutput("ext tdo2",      32'(tdo4), 32'd0);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("ext tdo3",      32'(tdo4), 32'd1);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("ext shift jtag", 32'(jtag4), 32'h7);
        applyStimulus(EXIT1_IR, 1'b0);
        checkOutput("ext exit irUpd", 32'(irUpd4), 32'd0);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("ext jtag",      32'(jtag4), 32'h2);
        checkOutput("ext sel",       32'(sel4), 32'(SEL_EXTEST));
        checkOutput("ext testMode",  32'(testMode4), 32'd1);
        checkOutput("ext irUpd",     32'(irUpd4), 32'd1);
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        checkOutput("ext irUpd low", 32'(irUpd4), 32'd0);
        checkOutput("ext jtag hold", 32'(jtag4), 32'h2);

        // 4'hC is not a supported opcode and must commit as BYPASS.
        applyStimulus(CAPTURE_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(EXIT1_IR, 1'b0);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("unsup jtag",     32'(jtag4), 32'hF);
        checkOutput("unsup sel",      32'(sel4), 32'(SEL_BYPASS));
        checkOutput("unsup testMode", 32'(testMode4), 32'd0);
        checkOutput("unsup irUpd",    32'(irUpd4), 32'd1);
        applyStimulus(RUN_TEST_IDLE, 1'b0);

        // USERCODE (4'h8) is not a test-mode instruction.
        applyStimulus(CAPTURE_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("user jtag",     32'(jtag4), 32'h8);
        checkOutput("user sel",      32'(sel4), 32'(SEL_USERCODE));
        checkOutput("user testMode", 32'(testMode4), 32'd0);
        applyStimulus(RUN_TEST_IDLE, 1'b0);

        // HIGHZ shifted in two halves around a 5-cycle Pause-IR.
        cap4 = 2'b00;
        applyStimulus(CAPTURE_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(EXIT1_IR, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(PAUSE_IR, 1'b1);
            checkOutput("pause jtag", 32'(jtag4), 32'h8);
            checkOutput("pause tdo",  32'(tdo4), 32'd0);
        end
        applyStimulus(EXIT2_IR, 1'b1);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(EXIT1_IR, 1'b0);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("hz jtag",     32'(jtag4), 32'h9);
        checkOutput("hz sel",      32'(sel4), 32'(SEL_HIGHZ));
        checkOutput("hz testMode", 32'(testMode4), 32'd1);
        checkOutput("hz irUpd",    32'(irUpd4), 32'd1);
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        checkOutput("hz irUpd low", 32'(irUpd4), 32'd0);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("recommit jtag",  32'(jtag4), 32'h9);
        checkOutput("recommit irUpd", 32'(irUpd4), 32'd1);
        applyStimulus(RUN_TEST_IDLE, 1'b0);

        // EXTEST, then Test-Logic-Reset restores IDCODE.
        applyStimulus(CAPTURE_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("tlr pre jtag", 32'(jtag4), 32'h2);
        applyStimulus(TEST_LOGIC_RESET, 1'b0);
        checkOutput("tlr jtag",     32'(jtag4), 32'h7);
        checkOutput("tlr sel",      32'(sel4), 32'(SEL_IDCODE));
        checkOutput("tlr tdo",      32'(tdo4), 32'd1);
        checkOutput("tlr irUpd",    32'(irUpd4), 32'd0);
        checkOutput("tlr testMode", 32'(testMode4), 32'd0);
        applyStimulus(RUN_TEST_IDLE, 1'b0);

        // EXTEST again, then rst in the middle of a Shift-IR.
        applyStimulus(CAPTURE_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b1);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        applyStimulus(UPDATE_IR, 1'b0);
        checkOutput("rstmid pre jtag", 32'(jtag4), 32'h2);
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        applyStimulus(CAPTURE_IR, 1'b0);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("rstmid pre tdo", 32'(tdo4), 32'd0);
        rst = 1'b1;
        applyStimulus(SHIFT_IR, 1'b0);
        rst = 1'b0;
        checkOutput("rstmid jtag",  32'(jtag4), 32'h7);
        checkOutput("rstmid tdo",   32'(tdo4), 32'd1);
        checkOutput("rstmid sel",   32'(sel4), 32'(SEL_IDCODE));
        checkOutput("rstmid irUpd", 32'(irUpd4), 32'd0);

        // 6-bit instance: capture 4'hA -> 6'b101001, shifted out LSB first.
        applyStimulus(RUN_TEST_IDLE, 1'b0);
        applyStimulus(CAPTURE_IR, 1'b0);
        checkOutput("w6 tdo0", 32'(tdo6), 32'd1);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("w6 tdo1", 32'(tdo6), 32'd0);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("w6 tdo2", 32'(tdo6), 32'd0);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("w6 tdo3", 32'(tdo6), 32'd1);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("w6 tdo4", 32'(tdo6), 32'd0);
        applyStimulus(SHIFT_IR, 1'b0);
        checkOutput("w6 tdo5", 32'(tdo6), 32'd1);
        checkOutput("w6 jtag hold", 32'(jtag6), 32'h07);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ir_shift.md
IR_SHIFT -- requirements
Module: ir_shift

Interface
REQ-001 Parameter IR_WIDTH, default 4, instruction register length in bits; legal range 2..8.
REQ-002 Parameter IDCODE_OP, default 4'h7 zero-extended to IR_WIDTH, opcode loaded on TAP reset.
REQ-003 Parameter USE_IDCODE, default 1; when 0, TAP reset loads BYPASS (all ones) instead of IDCODE_OP.
REQ-004 TCK  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 TDI  input  1  serial test data in.
REQ-007 state  input  4  current TAP controller state, using the team's TAP state encoding.
REQ-008 capture_status  input  IR_WIDTH-2  design-specific bits captured into IR[IR_WIDTH-1:2] in Capture-IR.
REQ-009 TDO_IR  output  1  serial out, equal to shift register bit 0 (combinational from the register).
REQ-010 JTAG_IR  output  IR_WIDTH  active (updated) instruction.
REQ-011 sel_bypass, sel_idcode, sel_usercode, sel_sample, sel_extest, sel_intest, sel_runbist, sel_clamp, sel_highz  output  1 each  one-hot decode of JTAG_IR.
REQ-012 test_mode  output  1  high when JTAG_IR is EXTEST, INTEST, RUNBIST, CLAMP or HIGHZ.
REQ-013 ir_updated  output  1  one-TCK pulse in the cycle after JTAG_IR is written by Update-IR.

Function
REQ-014 The shift register (IR_WIDTH bits) and JTAG_IR are separate registers; JTAG_IR changes only in Test-Logic-Reset or Update-IR.
REQ-015 state==TEST_LOGIC_RESET: JTAG_IR <= reset opcode (REQ-002/003); shift register <= reset opcode; ir_updated <= 0.
REQ-016 state==CAPTURE_IR: shift register <= {capture_status, 2'b01}; JTAG_IR unchanged.
REQ-017 state==SHIFT_IR: shift register <= {TDI, shreg[IR_WIDTH-1:1]} (LSB first out on TDO_IR); one bit per TCK, no limit on shift count.
REQ-018 state==UPDATE_IR: JTAG_IR <= shift register when the value is a supported opcode; otherwise JTAG_IR <= BYPASS (all ones).
REQ-019 Supported opcodes: BYPASS all ones, SAMPLE 1, EXTEST 2, INTEST 3, RUNBIST 4, CLAMP 5, IDCODE 7, USERCODE 8, HIGHZ 9 (zero-extended to IR_WIDTH); when IR_WIDTH < 4, only opcodes that fit are supported and all others map to BYPASS.
REQ-020 All other states (Pause-IR, Exit1/2-IR, all DR states, Run-Test-Idle, Select-*): shift register and JTAG_IR hold.
REQ-021 Decode outputs and test_mode are combinational from JTAG_IR; exactly one sel_* is high at all times after reset.
REQ-022 ir_updated is 1 for exactly one cycle after each Update-IR cycle, including when the new value equals the old.
REQ-023 Repeated Update-IR without an intervening Shift-IR re-commits the held shift register value.

Reset
REQ-024 rst high: JTAG_IR <= reset opcode, shift register <= reset opcode, ir_updated <= 0; rst overrides any state, including mid-Shift-IR.
REQ-025 Post-reset outputs: sel_idcode=1 (or sel_bypass=1 if USE_IDCODE=0); all other sel_*=0; test_mode=0; TDO_IR = bit 0 of reset opcode.

Structure
REQ-026 TAP state encodings and opcode constants live in shared package jtag_pkg, which the TAP controller and DR blocks also use.
REQ-027 Opcode validation and one-hot decode sit in combinational sub-module ir_decode (IR_WIDTH parameter), instantiated once.

Verification
REQ-028 rst=1 for 1 cycle -> JTAG_IR=4'h7, sel_idcode=1, test_mode=0, TDO_IR=1.
REQ-029 Capture-IR with capture_status=2'b10, then 4 Shift-IR cycles with TDI=0,1,0,0 -> TDO_IR sequence 1,0,0,1; Update-IR -> JTAG_IR=4'h2, sel_extest=1, test_mode=1, ir_updated pulses once.
REQ-030 Shift in 4'hC (unsupported), then Update-IR -> JTAG_IR=4'hF, sel_bypass=1.
REQ-031 Shift 2 bits of 4'h9, Pause-IR for 5 cycles, Exit2-IR, shift 2 more bits, then Update-IR -> JTAG_IR=4'h9, sel_highz=1; JTAG_IR unchanged throughout the pause.
REQ-032 JTAG_IR=4'h2, then state=TEST_LOGIC_RESET for 1 cycle -> JTAG_IR=4'h7; repeat with rst asserted mid-Shift-IR -> same result.
REQ-033 IR_WIDTH=6 instance: Capture-IR with capture_status=4'hA -> 6 shifts produce TDO_IR sequence 1,0,0,1,0,1.
